// File: rtl/uc_mem_pkg.sv
// Shared definitions for the uCode memory arbiter: state encoding and default widths.
package uc_mem_pkg;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    localparam int DEF_DATA_SZ    = 16;
    localparam int DEF_ADDR_SZ    = 10;
    localparam int DEF_STARVE_MAX = 8;

endpackage

// File: rtl/uc_mem_arb.sv
// uCode memory arbiter: CPU and host share one single-port BRAM.
// The CPU has priority. The host can lock the memory for burst loads.
// Optional macro STARVE_GUARD_EN adds a starvation counter. When the counter
// reaches STARVE_MAX, the host wins the next contested cycle.
module uc_mem_arb
    import uc_mem_pkg::*;
#(
    parameter int DATA_SZ    = DEF_DATA_SZ,
    parameter int ADDR_SZ    = DEF_ADDR_SZ,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_c_req,
    input  logic               i_c_wr,
    input  logic [ADDR_SZ-1:0] i_c_addr,
    input  logic [DATA_SZ-1:0] i_c_wdata,
    output logic               o_c_gnt,
    output logic               o_c_rvalid,
    input  logic               i_h_req,
    input  logic               i_h_wr,
    input  logic [ADDR_SZ-1:0] i_h_addr,
    input  logic [DATA_SZ-1:0] i_h_wdata,
    input  logic               i_h_lock,
    output logic               o_h_gnt,
    output logic               o_h_rvalid,
    output logic [DATA_SZ-1:0] o_rdata,
    output logic               o_mem_wr,
    output logic [ADDR_SZ-1:0] o_mem_addr,
    output logic [DATA_SZ-1:0] o_mem_wdata,
    input  logic [DATA_SZ-1:0] i_mem_rdata
);

    arb_state_e         state_q, state_d;
    logic               c_gnt, h_gnt;
    logic               host_force;
    logic               c_rvalid_q, h_rvalid_q;
    logic [ADDR_SZ-1:0] addr_q, addr_d;
    logic [DATA_SZ-1:0] wdata_q, wdata_d;

`ifdef STARVE_GUARD_EN
    // Width covers 0..STARVE_MAX inclusive and is never zero.
    localparam int CNT_W = $clog2(STARVE_MAX + 2);

    logic [CNT_W-1:0] starve_q, starve_d;

    // Count host denials in NORMAL, saturate at STARVE_MAX, clear on any host grant.
    always_comb begin
        starve_d   = starve_q;
        host_force = (starve_q == CNT_W'(STARVE_MAX));
        if (h_gnt) begin
            starve_d = '0;
        end else if ((state_q == ST_NORMAL) && i_h_req && !host_force) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end
`else
    logic [31:0] unused_starve_max;
    assign unused_starve_max = 32'(STARVE_MAX);
    assign host_force        = 1'b0;
`endif

    // Grant decision and lock state transitions.
    always_comb begin
        c_gnt   = 1'b0;
        h_gnt   = 1'b0;
        state_d = state_q;
        case (state_q)
            ST_NORMAL: begin
                if (host_force && i_h_req) begin
                    h_gnt = 1'b1;
                end else begin
                    c_gnt = i_c_req;
                    h_gnt = i_h_req && !i_c_req;
                end
                if (h_gnt && i_h_lock) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                // Releasing the lock with a request pending still serves the host this cycle.
                h_gnt = i_h_req;
                if (!i_h_lock) state_d = ST_NORMAL;
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    // Memory port mux. Address and data hold their last value when no request is granted.
    always_comb begin
        o_mem_wr = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        if (c_gnt) begin
            o_mem_wr = i_c_wr;
            addr_d   = i_c_addr;
            wdata_d  = i_c_wdata;
        end else if (h_gnt) begin
            o_mem_wr = i_h_wr;
            addr_d   = i_h_addr;
            wdata_d  = i_h_wdata;
        end
    end

    // State, held port values and read-valid pipeline.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_NORMAL;
            addr_q     <= '0;
            wdata_q    <= '0;
            c_rvalid_q <= 1'b0;
            h_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            c_rvalid_q <= c_gnt && !i_c_wr;
            h_rvalid_q <= h_gnt && !i_h_wr;
        end
    end

    assign o_c_gnt     = c_gnt;
    assign o_h_gnt     = h_gnt;
    assign o_c_rvalid  = c_rvalid_q;
    assign o_h_rvalid  = h_rvalid_q;
    assign o_mem_addr  = addr_d;
    assign o_mem_wdata = wdata_d;
    assign o_rdata     = i_mem_rdata;

endmodule

// File: tb/tb_uc_mem_arb.sv
// Testbench for uc_mem_arb: a BRAM model, directed scenarios and randomized traffic.
// A rule-level reference model checks every cycle.
module tb_uc_mem_arb;

    localparam int DW   = 16;
    localparam int AW   = 10;
    localparam int SMAX = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          c_req, c_wr, h_req, h_wr, h_lock;
    logic [AW-1:0] c_addr, h_addr;
    logic [DW-1:0] c_wdata, h_wdata;
    logic          o_c_gnt, o_c_rvalid, o_h_gnt, o_h_rvalid;
    logic [DW-1:0] o_rdata;
    logic          o_mem_wr;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uc_mem_arb #(.DATA_SZ(DW), .ADDR_SZ(AW), .STARVE_MAX(SMAX)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_c_req(c_req), .i_c_wr(c_wr), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
        .o_c_gnt(o_c_gnt), .o_c_rvalid(o_c_rvalid),
        .i_h_req(h_req), .i_h_wr(h_wr), .i_h_addr(h_addr), .i_h_wdata(h_wdata),
        .i_h_lock(h_lock), .o_h_gnt(o_h_gnt), .o_h_rvalid(o_h_rvalid),
        .o_rdata(o_rdata), .o_mem_wr(o_mem_wr), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // Single-port BRAM: 1-cycle read latency, no read on write cycles.
    logic [DW-1:0] bram [1<<AW];
    always @(posedge clk) begin
        if (o_mem_wr) bram[o_mem_addr] <= o_mem_wdata;
        else          mem_rdata        <= bram[o_mem_addr];
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [1<<AW];
    bit            m_locked;
    int            m_starve;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            m_crv, m_hrv;
    logic [DW-1:0] m_rdata;

    // Values sampled in the last step, for the directed checks.
    logic          g_c, g_h;
    logic [DW-1:0] s_rdata;

    function automatic logic [DW-1:0] pat(input int a);
        return DW'((a * 37) ^ 16'h5a5a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_starve = 0; m_addr = '0; m_wdata = '0; m_crv = 0; m_hrv = 0;
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model.
    task automatic step(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input logic hr, input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                        input logic hl);
        bit            ec, eh, ewr;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clk);
        c_req = cr; c_wr = cw; c_addr = ca; c_wdata = cd;
        h_req = hr; h_wr = hw; h_addr = ha; h_wdata = hd; h_lock = hl;
        #1;
        if (m_locked) begin
            ec = 0; eh = hr;
        end else begin
            ec = cr; eh = hr && !cr;
`ifdef STARVE_GUARD_EN
            if (m_starve >= SMAX && hr) begin ec = 0; eh = 1; end
`endif
        end
        ewr = 0; ea = m_addr; ed = m_wdata;
        if (ec)      begin ewr = cw; ea = ca; ed = cd; end
        else if (eh) begin ewr = hw; ea = ha; ed = hd; end
        chk("c_gnt", 32'(o_c_gnt), 32'(ec));
        chk("h_gnt", 32'(o_h_gnt), 32'(eh));
        chk("mem_wr", 32'(o_mem_wr), 32'(ewr));
        chk("mem_addr", 32'(o_mem_addr), 32'(ea));
        chk("mem_wdata", 32'(o_mem_wdata), 32'(ed));
        chk("c_rvalid", 32'(o_c_rvalid), 32'(m_crv));
        chk("h_rvalid", 32'(o_h_rvalid), 32'(m_hrv));
        if (m_crv || m_hrv) chk("rdata", 32'(o_rdata), 32'(m_rdata));
        g_c = o_c_gnt; g_h = o_h_gnt; s_rdata = o_rdata;
        // Advance the model to the next cycle.
        m_crv = ec && !cw;
        m_hrv = eh && !hw;
        if (ec || eh) begin
            m_addr = ea; m_wdata = ed;
            if (ewr) ref_mem[ea] = ed;
            else     m_rdata = ref_mem[ea];
        end
        if (eh) m_starve = 0;
        else if (!m_locked && hr && m_starve < SMAX) m_starve++;
        if (!m_locked) m_locked = eh && hl;
        else           m_locked = hl;
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    initial begin
        bit lk;
        for (int i = 0; i < (1 << AW); i++) begin
            bram[i] = pat(i); ref_mem[i] = pat(i);
        end
        {c_req, c_wr, h_req, h_wr, h_lock} = '0;
        c_addr = '0; h_addr = '0; c_wdata = '0; h_wdata = '0;
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("rst_c_rvalid", 32'(o_c_rvalid), 0);
        chk("rst_h_rvalid", 32'(o_h_rvalid), 0);
        chk("rst_mem_addr", 32'(o_mem_addr), 0);
        chk("rst_mem_wdata", 32'(o_mem_wdata), 0);
        chk("rst_mem_wr", 32'(o_mem_wr), 0);
        @(negedge clk); rst_n = 1'b1;

        // CPU read alone: granted now, data valid next cycle.
        step(1, 0, 10'h010, '0, 0, 0, '0, '0, 0);
        chk("r033_gnt", 32'(g_c), 1);
        idle();
        chk("r033_rdata", 32'(s_rdata), 32'(pat(16'h010)));

        // Contention: CPU first, host write goes through on the first idle CPU cycle.
        step(1, 0, 10'h030, '0, 1, 1, 10'h020, 16'h1234, 0);
        chk("r034_cpu", 32'(g_c), 1);
        chk("r034_hwait", 32'(g_h), 0);
        step(0, 0, '0, '0, 1, 1, 10'h020, 16'h1234, 0);
        chk("r034_host", 32'(g_h), 1);
        step(1, 0, 10'h020, '0, 0, 0, '0, '0, 0);
        idle();
        chk("r034_mem", 32'(s_rdata), 32'h1234);

        // Host lock burst while the CPU keeps requesting.
        step(0, 0, '0, '0, 1, 1, 10'h100, 16'hA000, 1);
        chk("r035_h0", 32'(g_h), 1);
        for (int k = 1; k < 4; k++) begin
            step(1, 0, 10'h005, '0, 1, 1, AW'(10'h100 + k), DW'(16'hA000 + k), 1);
            chk("r035_h", 32'(g_h), 1);
            chk("r035_c", 32'(g_c), 0);
        end
        step(1, 0, 10'h005, '0, 0, 0, '0, '0, 0);
        chk("r035_rel_c", 32'(g_c), 0);
        step(1, 0, 10'h101, '0, 0, 0, '0, '0, 0);
        chk("r035_cpu_back", 32'(g_c), 1);
        idle();
        chk("r035_mem", 32'(s_rdata), 32'hA001);

        // Continuous contention: the host wins only when starvation guarding is built in.
        for (int k = 0; k < 9; k++) begin
            step(1, 0, 10'h007, '0, 1, 0, 10'h008, '0, 0);
`ifdef STARVE_GUARD_EN
            chk("r036_h", 32'(g_h), (k == 8) ? 1 : 0);
`else
            chk("r036_h", 32'(g_h), 0);
`endif
        end
        step(1, 0, 10'h007, '0, 1, 0, 10'h008, '0, 0);
        chk("r036_after", 32'(g_c), 1);
        idle();

        // Reset right after a CPU read grant kills the pending rvalid.
        step(1, 0, 10'h010, '0, 0, 0, '0, '0, 0);
        @(posedge clk); #1;
        chk("r037_pre", 32'(o_c_rvalid), 1);
        c_req = 0; h_req = 0; h_lock = 0;
        rst_n = 1'b0;
        #1;
        chk("r037_rvalid", 32'(o_c_rvalid), 0);
        chk("r037_addr", 32'(o_mem_addr), 0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        step(1, 0, 10'h011, '0, 1, 0, 10'h012, '0, 0);
        chk("r037_normal", 32'(g_c), 1);

        // Randomized traffic.
        lk = 0;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 7) == 0) lk = !lk;
            step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 31)), DW'($urandom),
                 $urandom_range(0, 4) > 1,   $urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)), DW'($urandom),
                 lk);
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
